shiftreg_serdes: RTL and testbench

Parametrised universal shift register with a burst serialiser/deserialiser engine. It supports parallel load, single-step shifts in either direction (logical, arithmetic, rotate), and a K-bits-per-step shift step. An automatic burst shifts a full word out on `sout` while capturing `sin`, paced by `en`. It sits between datapath registers and bit-serial links or multi-cycle shift/rotate operations.

---
 rtl/shiftreg_serdes.sv | 131 +++++++++++++
 tb/tb_shiftreg_serdes.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_serdes.sv
// shiftreg_serdes: universal shift register with a burst serialiser/deserialiser.
// Parallel load, single-step logical/arithmetic/rotate shifts in either direction,
// K bits per step, and an en-paced burst that moves a full word through sout/sin.

module shiftreg_serdes #(
  parameter int W = 8,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  input  logic         load,
  input  logic         shift,
  input  logic         dir,
  input  logic [1:0]   mode,
  input  logic [K-1:0] sin,
  input  logic         start,
  input  logic         en,
  output logic [W-1:0] out,
  output logic [K-1:0] sout,
  output logic         busy,
  output logic         done
);

  localparam int N  = W / K;
  localparam int CW = $clog2(N + 1);

  // Reject geometries where a word is not a whole number of K-bit groups.
  generate
    if (W < 2 || K < 1 || K >= W || (W % K) != 0) begin : g_bad_params
      $error("shiftreg_serdes: illegal W/K combination");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   data, data_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           dir_lat, dir_lat_nxt;
  logic [1:0]     mode_lat, mode_lat_nxt;
  logic           done_nxt;

  logic           eff_dir;
  logic [1:0]     eff_mode;
  logic [K-1:0]   fill_left;
  logic [K-1:0]   fill_right;
  logic [W-1:0]   stepped;

  // A running burst keeps the direction and mode captured at start.
  assign eff_dir  = (state == RUN) ? dir_lat  : dir;
  assign eff_mode = (state == RUN) ? mode_lat : mode;

  assign out  = data;
  assign busy = (state == RUN);
  assign sout = eff_dir ? data[K-1:0] : data[W-1:W-K];

  // Compute the value the register would take after one step in the effective direction/mode.
  always_comb begin
    fill_left  = sin;
    fill_right = sin;
    stepped    = data;
    if (eff_mode == 2'b10) begin
      fill_left = data[W-1:W-K];
    end
    case (eff_mode)
      2'b01:   fill_right = {K{data[W-1]}};
      2'b10:   fill_right = data[K-1:0];
      default: fill_right = sin;
    endcase
    if (eff_dir) begin
      stepped = {fill_right, data[W-1:K]};
    end else begin
      stepped = {data[W-K-1:0], fill_left};
    end
  end

  // Next-state logic: load beats a burst step, which beats start, which beats a manual shift.
  always_comb begin
    state_nxt    = state;
    data_nxt     = data;
    cnt_nxt      = cnt;
    dir_lat_nxt  = dir_lat;
    mode_lat_nxt = mode_lat;
    done_nxt     = 1'b0;
    if (load) begin
      data_nxt  = in;
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state == RUN) begin
      if (en) begin
        data_nxt = stepped;
        cnt_nxt  = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
    end else if (start) begin
      state_nxt    = RUN;
      cnt_nxt      = '0;
      dir_lat_nxt  = dir;
      mode_lat_nxt = mode;
    end else if (shift) begin
      data_nxt = stepped;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      data     <= '0;
      cnt      <= '0;
      dir_lat  <= 1'b0;
      mode_lat <= 2'b00;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      data     <= data_nxt;
      cnt      <= cnt_nxt;
      dir_lat  <= dir_lat_nxt;
      mode_lat <= mode_lat_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_shiftreg_serdes.sv
// tb_shiftreg_serdes: drives a K=1 and a K=2 instance (W=8) with shared controls,
// compares both against an arithmetic reference model, plus directed scenarios.

module tb_shiftreg_serdes;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in;
  logic       load, shift, dir, start, en;
  logic [1:0] mode;
  logic       sin1;
  logic [1:0] sin2;
  logic [7:0] out1, out2;
  logic       sout1;
  logic [1:0] sout2;
  logic       busy1, busy2, done1, done2;

  int total = 0;
  int bad   = 0;

  // Reference model state, index 0 is the K=1 instance, index 1 the K=2 instance.
  logic [7:0] mOut[2];
  bit         mBusy[2];
  bit         mDone[2];
  int         mLeft[2];
  bit         mDir[2];
  logic [1:0] mMode[2];

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  shiftreg_serdes #(.W(8), .K(1)) dut1 (
    .clk(clk), .rst(rst), .in(in), .load(load), .shift(shift), .dir(dir),
    .mode(mode), .sin(sin1), .start(start), .en(en),
    .out(out1), .sout(sout1), .busy(busy1), .done(done1)
  );

  shiftreg_serdes #(.W(8), .K(2)) dut2 (
    .clk(clk), .rst(rst), .in(in), .load(load), .shift(shift), .dir(dir),
    .mode(mode), .sin(sin2), .start(start), .en(en),
    .out(out2), .sout(sout2), .busy(busy2), .done(done2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] refStep(input logic [7:0] v, input logic d, input logic [1:0] m,
                                         input logic [1:0] s, input int k);
    int x;
    int mask;
    int fill;
    logic signed [7:0] sv;
    x    = int'(v);
    mask = (1 << k) - 1;
    if (!d) begin
      fill = (m == 2'b10) ? (x >> (8 - k)) : (int'(s) & mask);
      return 8'(((x << k) | fill) & 255);
    end
    if (m == 2'b01) begin
      sv = v;
      sv = sv >>> k;
      return sv;
    end
    fill = (m == 2'b10) ? (x & mask) : (int'(s) & mask);
    return 8'((x >> k) | (fill << (8 - k)));
  endfunction

  function automatic int refSout(input logic [7:0] v, input logic d, input int k);
    int mask;
    mask = (1 << k) - 1;
    return d ? (int'(v) & mask) : (int'(v) >> (8 - k));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mOut[i]  = 8'h00;
      mBusy[i] = 1'b0;
      mDone[i] = 1'b0;
      mLeft[i] = 0;
      mDir[i]  = 1'b0;
      mMode[i] = 2'b00;
    end
  endtask

  task automatic modelEdge();
    logic [1:0] s;
    int k;
    for (int i = 0; i < 2; i++) begin
      k = i + 1;
      s = (i == 0) ? {1'b0, sin1} : sin2;
      mDone[i] = 1'b0;
      if (load) begin
        mOut[i]  = in;
        mBusy[i] = 1'b0;
      end else if (mBusy[i]) begin
        if (en) begin
          mOut[i] = refStep(mOut[i], mDir[i], mMode[i], s, k);
          mLeft[i]--;
          if (mLeft[i] == 0) begin
            mBusy[i] = 1'b0;
            mDone[i] = 1'b1;
          end
        end
      end else if (start) begin
        mBusy[i] = 1'b1;
        mLeft[i] = 8 / k;
        mDir[i]  = dir;
        mMode[i] = mode;
      end else if (shift) begin
        mOut[i] = refStep(mOut[i], dir, mode, s, k);
      end
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic sh, input logic e,
                               input logic d, input logic [1:0] m, input logic [7:0] data,
                               input logic s1, input logic [1:0] s2);
    load  = ld;
    start = st;
    shift = sh;
    en    = e;
    dir   = d;
    mode  = m;
    in    = data;
    sin1  = s1;
    sin2  = s2;
  endtask

  task automatic tick();
    #1;
    checkOutput("sout1", 32'(sout1), 32'(refSout(mOut[0], mBusy[0] ? mDir[0] : dir, 1)));
    checkOutput("sout2", 32'(sout2), 32'(refSout(mOut[1], mBusy[1] ? mDir[1] : dir, 2)));
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("out1", 32'(out1), 32'(mOut[0]));
    checkOutput("busy1", 32'(busy1), 32'(mBusy[0]));
    checkOutput("done1", 32'(done1), 32'(mDone[0]));
    checkOutput("out2", 32'(out2), 32'(mOut[1]));
    checkOutput("busy2", 32'(busy2), 32'(mBusy[1]));
    checkOutput("done2", 32'(done2), 32'(mDone[1]));
  endtask

  initial begin
    logic [7:0] seqBits;
    logic [7:0] expBits;
    int cycles;
    int steps;
    logic e;

    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 2'b00);
    modelReset();
    #12;
    checkOutput("rst out", 32'(out1), 32'h0);
    checkOutput("rst busy", 32'(busy1), 32'h0);
    checkOutput("rst done", 32'(done1), 32'h0);
    checkOutput("rst sout", 32'(sout1), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] manual shifts");
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 8'hA5, 0, 2'b00); tick();
    applyStimulus(0, 0, 1, 0, 0, 2'b00, 8'h00, 1, 2'b01); tick();
    checkOutput("t1 lsl", 32'(out1), 32'h4B);
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 8'h96, 0, 2'b00); tick();
    applyStimulus(0, 0, 1, 0, 1, 2'b01, 8'h00, 0, 2'b00); tick();
    checkOutput("t2 asr", 32'(out1), 32'hCB);
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 8'h96, 0, 2'b00); tick();
    applyStimulus(0, 0, 1, 0, 1, 2'b10, 8'h00, 0, 2'b00); tick();
    checkOutput("t2 ror", 32'(out1), 32'h4B);

    $display("[TB] left burst");
    seqBits = 8'b0110_0001;
    expBits = 8'hA5;
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 8'hA5, 0, 2'b00); tick();
    applyStimulus(0, 1, 0, 1, 0, 2'b00, 8'h00, 0, 2'b00); tick();
    cycles = 1;
    checkOutput("t3 busy0", 32'(busy1), 32'h1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 2'b00, 8'h00, seqBits[7-i], 2'b00);
      #1;
      checkOutput($sformatf("t3 sout%0d", i), 32'(sout1), 32'(expBits[7-i]));
      tick();
      cycles++;
      if (i < 7) checkOutput($sformatf("t3 busy%0d", i + 1), 32'(busy1), 32'h1);
    end
    checkOutput("t3 done", 32'(done1), 32'h1);
    checkOutput("t3 busy end", 32'(busy1), 32'h0);
    checkOutput("t3 cycles", 32'(cycles), 32'd9);
    checkOutput("t3 data", 32'(out1), 32'h61);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 2'b00); tick();
    checkOutput("t3 done drop", 32'(done1), 32'h0);

    $display("[TB] stalled burst");
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 8'hA5, 0, 2'b00); tick();
    applyStimulus(0, 1, 0, 1, 0, 2'b00, 8'h00, 0, 2'b00); tick();
    cycles = 1;
    steps = 0;
    for (int c = 0; c < 30 && !done1; c++) begin
      e = !(c == 2 || c == 5 || c == 9);
      applyStimulus(0, c[0], ~c[0], e, c[1], 2'($urandom_range(3)), 8'h00,
                    e ? seqBits[7-steps] : 1'b0, 2'($urandom_range(3)));
      #1;
      if (e) checkOutput($sformatf("t4 sout%0d", steps), 32'(sout1), 32'(expBits[7-steps]));
      tick();
      cycles++;
      if (e) steps++;
    end
    checkOutput("t4 done", 32'(done1), 32'h1);
    checkOutput("t4 cycles", 32'(cycles), 32'd12);
    checkOutput("t4 data", 32'(out1), 32'h61);

    $display("[TB] K=2 right burst");
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 8'h1B, 0, 2'b00); tick();
    applyStimulus(0, 1, 0, 1, 1, 2'b00, 8'h00, 0, 2'b00); tick();
    cycles = 1;
    steps = 0;
    for (int c = 0; c < 20 && !done2; c++) begin
      applyStimulus(0, 0, 0, 1, 1, 2'b00, 8'h00, 1'($urandom_range(1)), 2'b00);
      #1;
      checkOutput($sformatf("t5 sout%0d", steps), 32'(sout2), 32'(3 - steps));
      tick();
      cycles++;
      steps++;
    end
    checkOutput("t5 done", 32'(done2), 32'h1);
    checkOutput("t5 steps", 32'(steps), 32'd4);
    checkOutput("t5 cycles", 32'(cycles), 32'd5);
    checkOutput("t5 data", 32'(out2), 32'h00);

    $display("[TB] abort and reset");
    applyStimulus(1, 0, 0, 0, 0, 2'b00, 8'hF0, 0, 2'b00); tick();
    applyStimulus(0, 1, 0, 1, 0, 2'b00, 8'h00, 0, 2'b00); tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 2'b00, 8'h00, 1, 2'b11); tick();
    end
    applyStimulus(1, 0, 0, 1, 0, 2'b00, 8'h3C, 1, 2'b11); tick();
    checkOutput("t6 abort out", 32'(out1), 32'h3C);
    checkOutput("t6 abort busy", 32'(busy1), 32'h0);
    checkOutput("t6 abort done", 32'(done1), 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 2'b00, 8'h00, 0, 2'b00); tick();
    checkOutput("t6 abort nodone", 32'(done1), 32'h0);

    applyStimulus(0, 1, 0, 1, 0, 2'b00, 8'h00, 0, 2'b00); tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 2'b00, 8'h00, 1, 2'b10); tick();
    end
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("t6 rst out", 32'(out1), 32'h0);
    checkOutput("t6 rst busy", 32'(busy1), 32'h0);
    checkOutput("t6 rst done", 32'(done1), 32'h0);
    checkOutput("t6 rst busy2", 32'(busy2), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1, 1, 0, 1, 0, 2'b00, 8'h5A, 0, 2'b00); tick();
    checkOutput("t6 ldst out", 32'(out1), 32'h5A);
    checkOutput("t6 ldst busy", 32'(busy1), 32'h0);

    $display("[TB] random phase");
    for (int c = 0; c < 500; c++) begin
      applyStimulus(($urandom_range(15) == 0), ($urandom_range(3) == 0), 1'($urandom_range(1)),
                    ($urandom_range(3) != 0), 1'($urandom_range(1)), 2'($urandom_range(3)),
                    8'($urandom_range(255)), 1'($urandom_range(1)), 2'($urandom_range(3)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
